// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the triggered ADC capture buffer.
package adc_capture_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 9;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StFill = 3'd1,
        StWait = 3'd2,
        StPost = 3'd3,
        StDone = 3'd4
    } state_t;

endpackage

// File: rtl/adc_capture_buffer_ram.sv
// DEPTH x 8 simple dual-port RAM: one write port, one registered read port.
module capture_ram #(
    parameter int unsigned ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Array carries no reset so it stays inferable as block RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered circular capture of the ADC sample stream with pre-trigger history
// and random-access readout relative to the oldest sample.
module adc_capture_buffer
    import adc_capture_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK_64MHZ,
    input  logic              MASTER_RST,
    input  logic              SAMPLE_STB,
    input  logic [7:0]        SAMPLE_IN,
    input  logic              ARM,
    input  logic              FORCE_TRIG,
    input  logic [7:0]        TRIG_LEVEL,
    input  logic              TRIG_SLOPE,
    input  logic [ADDR_W:0]   PRE_COUNT,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [7:0]        RD_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              TRIG_FORCED
);

    localparam int unsigned    DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] DEPTH_M1 = (ADDR_W + 1)'(DEPTH - 1);

    state_t              r_state, w_state_next;
    logic [ADDR_W-1:0]   r_wptr, r_start, r_pre;
    logic [ADDR_W:0]     r_cnt;
    logic [7:0]          r_prev;
    logic                r_prev_vld, r_force_pend, r_trig_forced;

    logic [ADDR_W-1:0]   w_pre_clamp, w_rd_idx;
    logic [ADDR_W:0]     w_post_init;
    logic                w_wr_en, w_trig, w_level_hit, w_force_now;

    assign w_pre_clamp = (PRE_COUNT >= (ADDR_W + 1)'(DEPTH)) ? ADDR_W'(DEPTH - 1)
                                                             : PRE_COUNT[ADDR_W-1:0];
    assign w_post_init = DEPTH_M1 - {1'b0, r_pre};
    assign w_force_now = r_force_pend | FORCE_TRIG;

    always_ff @(posedge CLK_64MHZ or posedge MASTER_RST) begin
        if (MASTER_RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wr_en      = 1'b0;
        w_trig       = 1'b0;
        // prev is meaningless until something has been written since ARM.
        if (TRIG_SLOPE == SLOPE_RISE) begin
            w_level_hit = r_prev_vld && (r_prev < TRIG_LEVEL) && (SAMPLE_IN >= TRIG_LEVEL);
        end else begin
            w_level_hit = r_prev_vld && (r_prev > TRIG_LEVEL) && (SAMPLE_IN <= TRIG_LEVEL);
        end
        if (ARM) begin
            w_state_next = (w_pre_clamp == '0) ? StWait : StFill;
        end else begin
            case (r_state)
                StFill: if (SAMPLE_STB) begin
                    w_wr_en = 1'b1;
                    if (r_cnt + CNT_ONE == {1'b0, r_pre}) w_state_next = StWait;
                end
                StWait: if (SAMPLE_STB) begin
                    w_wr_en = 1'b1;
                    if (w_force_now || w_level_hit) begin
                        w_trig       = 1'b1;
                        w_state_next = (w_post_init == '0) ? StDone : StPost;
                    end
                end
                StPost: if (SAMPLE_STB) begin
                    w_wr_en = 1'b1;
                    if (r_cnt == CNT_ONE) w_state_next = StDone;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK_64MHZ or posedge MASTER_RST) begin
        if (MASTER_RST) begin
            r_wptr        <= '0;
            r_start       <= '0;
            r_pre         <= '0;
            r_cnt         <= '0;
            r_prev        <= '0;
            r_prev_vld    <= 1'b0;
            r_force_pend  <= 1'b0;
            r_trig_forced <= 1'b0;
        end else if (ARM) begin
            r_pre         <= w_pre_clamp;
            r_cnt         <= '0;
            r_prev_vld    <= 1'b0;
            r_force_pend  <= 1'b0;
            r_trig_forced <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wptr     <= r_wptr + ADDR_W'(1);
                r_prev     <= SAMPLE_IN;
                r_prev_vld <= 1'b1;
            end
            if (r_state == StFill && SAMPLE_STB) r_cnt <= r_cnt + CNT_ONE;
            if (r_state == StPost && SAMPLE_STB) r_cnt <= r_cnt - CNT_ONE;
            if (r_state == StWait) begin
                if (w_trig) begin
                    // Trigger sample lands at r_wptr; the record starts PRE samples earlier.
                    r_start       <= r_wptr - r_pre;
                    r_cnt         <= w_post_init;
                    r_trig_forced <= w_force_now;
                    r_force_pend  <= 1'b0;
                end else if (FORCE_TRIG) begin
                    r_force_pend  <= 1'b1;
                end
            end
        end
    end

    assign w_rd_idx = r_start + RD_ADDR;

    capture_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (CLK_64MHZ),
        .i_rst   (MASTER_RST),
        .i_we    (w_wr_en),
        .i_waddr (r_wptr),
        .i_wdata (SAMPLE_IN),
        .i_raddr (w_rd_idx),
        .o_rdata (RD_DATA)
    );

    assign BUSY        = (r_state == StFill) || (r_state == StWait) || (r_state == StPost);
    assign DONE        = (r_state == StDone);
    assign TRIG_FORCED = r_trig_forced;

endmodule

// File: doc/adc_capture_buffer.md
# adc_capture_buffer

Triggered sample-capture buffer directly downstream of the ADC driver. Takes the 8-bit sample stream plus a one-cycle sample strobe in the 64 MHz domain and stores a circular record of 2^ADDR_W samples. The trigger sample sits at a programmable pre-trigger position in that record. Once the record is complete, the display/readout logic reads it back through a random-access port, with addresses relative to the oldest sample.

## Interface
Parameters:
- ADDR_W, 9 — record depth DEPTH = 2^ADDR_W samples (512).

Ports:
- CLK_64MHZ  in  1  global system clock; all logic on posedge.
- MASTER_RST  in  1  global reset, asynchronous, active-high.
- SAMPLE_STB  in  1  one-cycle pulse; SAMPLE_IN is valid this cycle.
- SAMPLE_IN  in  8  ADC sample (unsigned).
- ARM  in  1  pulse; starts a new capture.
- FORCE_TRIG  in  1  pulse; forces a trigger while waiting.
- TRIG_LEVEL  in  8  trigger threshold (unsigned).
- TRIG_SLOPE  in  1  0 = rising, 1 = falling.
- PRE_COUNT  in  ADDR_W+1  samples kept before the trigger sample; latched on ARM.
- RD_ADDR  in  ADDR_W  logical read index; 0 = oldest sample of the record.
- RD_DATA  out  8  record data, registered.
- BUSY  out  1  capture in progress.
- DONE  out  1  record complete; level signal.
- TRIG_FORCED  out  1  last record was ended by FORCE_TRIG.

## Operation
- States: IDLE, FILL, WAIT, POST, DONE.
- Reset values: state IDLE; BUSY, DONE, TRIG_FORCED, RD_DATA, write pointer, start pointer and counters all 0.
- ARM in any state (including mid-capture):
  - Latches PRE_COUNT, clamped to DEPTH-1 if it is DEPTH or more.
  - Clears the counters, the previous-sample-valid flag and the force-pending flag.
  - Moves to FILL; if the latched PRE_COUNT is 0, moves straight to WAIT.
- Sample writes: each SAMPLE_STB in FILL, WAIT or POST writes SAMPLE_IN to mem[wptr], then increments wptr modulo DEPTH. Strobes in IDLE and DONE are ignored.
- FILL: counts strobes; after the PRE_COUNT-th strobe, moves to WAIT. Triggers are not evaluated in FILL.
- WAIT: trigger is evaluated on each strobe, using prev (the last written sample) and cur (SAMPLE_IN).
  - Rising: prev < TRIG_LEVEL and cur >= TRIG_LEVEL.
  - Falling: prev > TRIG_LEVEL and cur <= TRIG_LEVEL.
  - prev is valid only after at least one sample has been written since ARM. With PRE_COUNT = 0, the first strobe cannot trigger.
- FORCE_TRIG in WAIT sets force-pending. A strobe arriving while force-pending is set, or in the same cycle as FORCE_TRIG, is the trigger sample, and TRIG_FORCED is set. FORCE_TRIG outside WAIT is ignored.
- On the trigger strobe:
  - The trigger sample is written at address T.
  - start pointer = (T - PRE_COUNT) mod DEPTH.
  - post counter = DEPTH-1-PRE_COUNT.
  - Moves to POST, or straight to DONE if the post count is 0.
- POST: decrements on each strobe; the strobe that takes the counter to 0 moves to DONE.
- DONE: writes stop; the record stays stable until the next ARM.
- BUSY = 1 in FILL, WAIT and POST. DONE = 1 in the DONE state only. TRIG_FORCED is cleared on ARM.
- Read: RD_DATA <= mem[(start pointer + RD_ADDR) mod DEPTH] every cycle. Reads during capture are permitted, but the data is not coherent.

## Timing
- Memory write happens on the posedge of the strobe cycle.
- State, BUSY and DONE change on the posedge ending the strobe cycle; DONE is visible the cycle after the final strobe.
- Read latency is 1 cycle from RD_ADDR to RD_DATA.
- The back-to-back strobe rate is 1 per cycle. Arbitrary gaps between strobes do not alter record content.
- MASTER_RST asserted mid-capture: immediate return to IDLE with all outputs at reset values. Memory contents are undefined and are not cleared.
- ARM and SAMPLE_STB in the same cycle: ARM wins; that sample is not written.

## Structure
- Package adc_capture_pkg holds:
  - the state encoding constants;
  - the default ADDR_W;
  - the slope constants SLOPE_RISE = 0 and SLOPE_FALL = 1.
- Sub-module capture_ram: DEPTH x 8 simple dual-port RAM with one write port and a registered read port, targeting block RAM.
- The top level holds the FSM, pointers, counters and the trigger comparator.

## Test plan
All scenarios use ADDR_W = 9, and the input is a ramp 0,1,…,255 repeating, one value per strobe, unless stated otherwise.
- Ramp, level 0x80, rising, PRE_COUNT 100 → trigger on input index 128. RD_ADDR 100 = 0x80, RD_ADDR 99 = 0x7F, RD_ADDR 0 = 0x1C, RD_ADDR 511 = 0x1B. DONE rises 1 cycle after the 540th strobe.
- PRE_COUNT 200 → the crossing at index 128 is ignored (still in FILL) and the trigger is at index 384. RD_ADDR 200 = 0x80, RD_ADDR 0 = 0xB8.
- Constant input 0x40, level 0x40, falling, PRE_COUNT 10 → no trigger, BUSY held at 1. FORCE_TRIG, then the next strobe → TRIG_FORCED = 1, and DONE after 501 further strobes.
- PRE_COUNT 0 → trigger sample at RD_ADDR 0. PRE_COUNT 600 → clamped to 511, trigger sample at RD_ADDR 511, and DONE the cycle after the trigger strobe.
- MASTER_RST pulsed during POST → BUSY = 0, DONE = 0, later strobes ignored. ARM during WAIT → restart in FILL with the fill count reset to 0.
- Scenario 1 repeated with SAMPLE_STB every 64 cycles → RD_DATA identical for all 512 addresses.
